// File: rtl/seg_marquee_if.sv
// Control and window bus for the seg_marquee scrolling-message engine.
// The master side drives scroll controls and the message; the slave side is the engine.
interface seg_marquee_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned MSG_LEN    = 10,
  parameter int unsigned CHAR_W     = 4,
  parameter int unsigned POS_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
);
  logic                         en;
  logic                         dir;
  logic                         load;
  logic [MSG_LEN*CHAR_W-1:0]    msg_in;
  logic [NUM_DIGITS*CHAR_W-1:0] char_out;
  logic [POS_W-1:0]             pos;
  logic                         step;
  logic                         wrap;

  modport master (
    output en, dir, load, msg_in,
    input  char_out, pos, step, wrap
  );

  modport slave (
    input  en, dir, load, msg_in,
    output char_out, pos, step, wrap
  );
endinterface

// File: rtl/seg_marquee.sv
// Scrolling-message engine: holds a message and presents a wrapping NUM_DIGITS-wide window of it,
// advancing one position every TICK_DIV enabled clocks in either direction.
module seg_marquee #(
  parameter int unsigned       NUM_DIGITS = 6,
  parameter int unsigned       MSG_LEN    = 10,
  parameter int unsigned       CHAR_W     = 4,
  parameter int unsigned       TICK_DIV   = 25_000_000,
  parameter logic [CHAR_W-1:0] BLANK      = CHAR_W'(2)
) (
  input logic          clk,
  input logic          rst_n,
  seg_marquee_if.slave bus
);

  localparam int unsigned POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned OUT_W = NUM_DIGITS * CHAR_W;

  localparam logic [POS_W-1:0] LastPos = POS_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICK_DIV - 1);

  logic [CHAR_W-1:0] msg_q [MSG_LEN];
  logic [CHAR_W-1:0] msg_d [MSG_LEN];
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  char_q, char_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              tick;
  logic [POS_W-1:0]  idx;

  assign tick = bus.en && (cnt_q == LastCnt);

  always_comb begin
    msg_d  = msg_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.load) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_d[i] = bus.msg_in[i*CHAR_W +: CHAR_W];
      end
      pos_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      if (!bus.dir) begin
        wrap_d = (pos_q == LastPos);
        pos_d  = wrap_d ? '0 : pos_q + 1'b1;
      end else begin
        wrap_d = (pos_q == '0);
        pos_d  = wrap_d ? LastPos : pos_q - 1'b1;
      end
    end else if (bus.en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Window is built from next-state so char_out always agrees with pos after the same edge.
  // A running index that wraps at LastPos replaces any modulo.
  always_comb begin
    char_d = '0;
    idx    = pos_d;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      char_d[k*CHAR_W +: CHAR_W] = msg_d[idx];
      idx = (idx == LastPos) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= BLANK;
      end
      pos_q  <= '0;
      cnt_q  <= '0;
      char_q <= {NUM_DIGITS{BLANK}};
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      msg_q  <= msg_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
      char_q <= char_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.char_out = char_q;
  assign bus.pos      = pos_q;
  assign bus.step     = step_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_seg_marquee.sv
// Directed bench for seg_marquee: the driver queues the expected window at each scroll step and a
// monitor checks every step/wrap pulse against that queue.
module tb_seg_marquee;

  localparam int unsigned NumDigits = 6;
  localparam int unsigned MsgLen    = 10;
  localparam int unsigned CharW     = 4;
  localparam int unsigned TickDiv   = 4;

  typedef struct packed {
    logic [3:0]  pos;
    logic [23:0] chars;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q [$];

  // Window for message 0..9 at each pos; slot 0 is the low nibble.
  logic [23:0] win_tab [10] = '{24'h543210, 24'h654321, 24'h765432, 24'h876543, 24'h987654,
                                24'h098765, 24'h109876, 24'h210987, 24'h321098, 24'h432109};

  seg_marquee_if #(.NUM_DIGITS(NumDigits), .MSG_LEN(MsgLen), .CHAR_W(CharW)) bus ();

  seg_marquee #(
    .NUM_DIGITS(NumDigits),
    .MSG_LEN   (MsgLen),
    .CHAR_W    (CharW),
    .TICK_DIV  (TickDiv),
    .BLANK     (4'd2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input logic [23:0] c, input logic w);
    exp_t r;
    r.pos   = 4'(p);
    r.chars = c;
    r.wrap  = w;
    exp_q.push_back(r);
  endtask

  task automatic step_window(input string name);
    repeat (TickDiv - 1) begin
      @(negedge clk);
      chk({name, "_nostep"}, 64'(bus.step), 64'd0);
    end
    @(negedge clk);
    chk({name, "_step"}, 64'(bus.step), 64'd1);
  endtask

  // Monitor: every step or wrap pulse consumes one expected record.
  always @(negedge clk) begin
    if (bus.step || bus.wrap) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got step=%0b wrap=%0b pos=%0d want no pulse at %0t",
                 bus.step, bus.wrap, bus.pos, $time);
      end else begin
        exp_t r;
        r = exp_q.pop_front();
        chk("mon_pos", 64'(bus.pos), 64'(r.pos));
        chk("mon_char", 64'(bus.char_out), 64'(r.chars));
        chk("mon_wrap", 64'(bus.wrap), 64'(r.wrap));
        chk("mon_step", 64'(bus.step), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.dir     = 1'b0;
    bus.load    = 1'b0;
    bus.msg_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_char", 64'(bus.char_out), 64'h222222);
    chk("rst_pos", 64'(bus.pos), 64'd0);
    chk("rst_step", 64'(bus.step), 64'd0);
    chk("rst_wrap", 64'(bus.wrap), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_char", 64'(bus.char_out), 64'h222222);
    chk("idle_pos", 64'(bus.pos), 64'd0);

    // Load 0..9 and scroll left a full lap.
    bus.load   = 1'b1;
    bus.en     = 1'b1;
    bus.msg_in = 40'h9876543210;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_char", 64'(bus.char_out), 64'h543210);
    chk("load_pos", 64'(bus.pos), 64'd0);
    for (int p = 1; p <= 10; p++) push(p % 10, win_tab[p % 10], p == 10);
    step_window("left1");
    chk("left1_pos", 64'(bus.pos), 64'd1);
    chk("left1_char", 64'(bus.char_out), 64'h654321);
    repeat (16) @(negedge clk);
    chk("left5_char", 64'(bus.char_out), 64'h098765);
    repeat (20) @(negedge clk);
    chk("lap_pos", 64'(bus.pos), 64'd0);
    chk("lap_wrap", 64'(bus.wrap), 64'd1);
    chk("lap_char", 64'(bus.char_out), 64'h543210);

    // Right scroll from 0 wraps to 9.
    bus.dir = 1'b1;
    push(9, 24'h432109, 1'b1);
    step_window("right");
    chk("right_pos", 64'(bus.pos), 64'd9);
    chk("right_wrap", 64'(bus.wrap), 64'd1);
    chk("right_char", 64'(bus.char_out), 64'h432109);

    // Freeze at cnt=2 for 20 cycles.
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    repeat (20) @(negedge clk);
    chk("freeze_pos", 64'(bus.pos), 64'd9);
    chk("freeze_step", 64'(bus.step), 64'd0);
    bus.en = 1'b1;
    push(8, 24'h321098, 1'b0);
    @(negedge clk);
    chk("thaw_nostep", 64'(bus.step), 64'd0);
    @(negedge clk);
    chk("thaw_step", 64'(bus.step), 64'd1);
    chk("thaw_pos", 64'(bus.pos), 64'd8);

    // Walk right to pos 3, then load on the tick edge.
    for (int p = 7; p >= 3; p--) push(p, win_tab[p], 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_coll_pos", 64'(bus.pos), 64'd3);
    repeat (3) @(negedge clk);
    bus.load   = 1'b1;
    bus.msg_in = 40'h3210FEDCBA;
    @(negedge clk);
    bus.load = 1'b0;
    bus.dir  = 1'b0;
    chk("coll_pos", 64'(bus.pos), 64'd0);
    chk("coll_step", 64'(bus.step), 64'd0);
    chk("coll_wrap", 64'(bus.wrap), 64'd0);
    chk("coll_char", 64'(bus.char_out), 64'hFEDCBA);
    push(1, 24'h0FEDCB, 1'b0);
    step_window("coll_after");
    chk("coll_after_pos", 64'(bus.pos), 64'd1);

    // Reload 0..9, scroll to pos 7, then reset mid-pulse between edges.
    bus.load   = 1'b1;
    bus.msg_in = 40'h9876543210;
    @(negedge clk);
    bus.load = 1'b0;
    chk("reload_char", 64'(bus.char_out), 64'h543210);
    for (int p = 1; p <= 7; p++) push(p, win_tab[p], 1'b0);
    repeat (28) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_char", 64'(bus.char_out), 64'h222222);
    chk("arst_pos", 64'(bus.pos), 64'd0);
    chk("arst_step", 64'(bus.step), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 24'h222222, 1'b0);
    step_window("post_rst");
    chk("post_rst_pos", 64'(bus.pos), 64'd1);
    chk("post_rst_char", 64'(bus.char_out), 64'h222222);

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
